// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM counter and the PWM generator that consumes count_val.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PSC_W_DEF = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Bit positions inside the functions field of the PWM control word.
    localparam int FN_EN_BIT  = 0;
    localparam int FN_DIR_BIT = 1;
    localparam int FN_CLR_BIT = 2;
    localparam int FN_POL_BIT = 3;
    localparam int FN_W       = 4;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: raises tick once every prescale+1 enabled cycles.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;

    // >= rather than == so a prescale lowered below the running count recovers at once.
    assign tick = en && (psc_cnt >= prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
        end else if (en) begin
            psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// Up/down period counter with wrap pulse for the PWM generator.
// Define PWM_CNT_SHADOW_EN to latch period/prescale into shadow registers.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] count_val,
    output logic             ovf
);

    logic [CNT_W-1:0] per_act;
    logic [PSC_W-1:0] psc_act;
    logic             tick;
    logic [CNT_W:0]   nxt;
    logic             wrap;

    // Returns {wrap, next value}; out-of-range counts are folded back on the wrap path.
    function automatic logic [CNT_W:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] per,
        input logic             dir
    );
        if (dir == DIR_UP) begin
            if (cnt >= per) return {1'b1, {CNT_W{1'b0}}};
            else            return {1'b0, cnt + 1'b1};
        end else begin
            if (cnt == '0 || cnt > per) return {1'b1, per};
            else                        return {1'b0, cnt - 1'b1};
        end
    endfunction

    pwm_prescaler #(
        .PSC_W    (PSC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (count_reset),
        .prescale (psc_act),
        .tick     (tick)
    );

    assign nxt  = next_count(count_val, per_act, upnotdown);
    assign wrap = tick && nxt[CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_val <= '0;
            ovf       <= 1'b0;
        end else if (count_reset) begin
            count_val <= '0;
            ovf       <= 1'b0;
        end else if (tick) begin
            count_val <= nxt[CNT_W-1:0];
            ovf       <= nxt[CNT_W];
        end else begin
            ovf       <= 1'b0;
        end
    end

`ifdef PWM_CNT_SHADOW_EN
    logic [CNT_W-1:0] per_sh;
    logic [PSC_W-1:0] psc_sh;

    // New settings only take hold at a cycle boundary, on clear, or while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh <= '0;
            psc_sh <= '0;
        end else if (count_reset || !en || wrap) begin
            per_sh <= period;
            psc_sh <= prescale;
        end
    end

    assign per_act = per_sh;
    assign psc_act = psc_sh;
`else
    assign per_act = period;
    assign psc_act = prescale;
`endif

endmodule

// File: tb/tb_pwm_counter.sv
// Scoreboard bench for pwm_counter: behavioural model pushes expected results, monitor compares.
module tb_pwm_counter;

    localparam int CNT_W = 16;
    localparam int PSC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             count_reset;
    logic             upnotdown;
    logic [CNT_W-1:0] period;
    logic [PSC_W-1:0] prescale;
    logic [CNT_W-1:0] count_val;
    logic             ovf;

    pwm_counter #(
        .CNT_W       (CNT_W),
        .PSC_W       (PSC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .count_val   (count_val),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [CNT_W:0] sb[$];

    int m_cnt;
    int m_psc;
`ifdef PWM_CNT_SHADOW_EN
    int m_per_sh;
    int m_psc_sh;
`endif

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_psc = 0;
`ifdef PWM_CNT_SHADOW_EN
        m_per_sh = 0;
        m_psc_sh = 0;
`endif
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now applied.
    task automatic model_step();
        int  ap;
        int  aps;
        int  ovf_e;
        bit  capture;
        bit  tk;
        logic [CNT_W:0] e;
`ifdef PWM_CNT_SHADOW_EN
        ap  = m_per_sh;
        aps = m_psc_sh;
`else
        ap  = int'(period);
        aps = int'(prescale);
`endif
        ovf_e   = 0;
        capture = 1'b0;
        if (count_reset) begin
            m_cnt   = 0;
            m_psc   = 0;
            capture = 1'b1;
        end else if (!en) begin
            capture = 1'b1;
        end else begin
            tk    = (m_psc >= aps);
            m_psc = tk ? 0 : m_psc + 1;
            if (tk) begin
                if (upnotdown) begin
                    if (m_cnt < ap) m_cnt = m_cnt + 1;
                    else begin m_cnt = 0; ovf_e = 1; end
                end else begin
                    if (m_cnt > 0 && m_cnt <= ap) m_cnt = m_cnt - 1;
                    else begin m_cnt = ap; ovf_e = 1; end
                end
            end
            capture = (ovf_e != 0);
        end
`ifdef PWM_CNT_SHADOW_EN
        if (capture) begin
            m_per_sh = int'(period);
            m_psc_sh = int'(prescale);
        end
`else
        if (capture) ap = 0;
`endif
        e = {ovf_e[0], m_cnt[CNT_W-1:0]};
        sb.push_back(e);
    endtask

    task automatic cyc(input logic e, input logic cr, input logic ud,
                       input int per, input int psc);
        @(negedge clk);
        en          = e;
        count_reset = cr;
        upnotdown   = ud;
        period      = per[CNT_W-1:0];
        prescale    = psc[PSC_W-1:0];
        model_step();
    endtask

    task automatic run(input int n, input logic e, input logic ud,
                       input int per, input int psc);
        for (int i = 0; i < n; i++) cyc(e, 1'b0, ud, per, psc);
    endtask

    task automatic until_cnt(input int target, input logic ud, input int per, input int psc);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 200) begin
            cyc(1'b1, 1'b0, ud, per, psc);
            guard++;
        end
        if (guard >= 200) check("reach_count", m_cnt, target);
    endtask

    always @(posedge clk) begin
        logic [CNT_W:0] e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count_val", int'(count_val), int'(e[CNT_W-1:0]));
            check("ovf", int'(ovf), int'(e[CNT_W]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [CNT_W-1:0] r_per;
    logic [PSC_W-1:0] r_psc;
    logic             r_ud;
    int               max_seen;

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        count_reset = 1'b0;
        upnotdown   = 1'b1;
        period      = '0;
        prescale    = '0;
        model_reset();
        #12;
        check("reset_count_val", int'(count_val), 0);
        check("reset_ovf", int'(ovf), 0);

        @(negedge clk);
        rst_n = 1'b1;
        model_step();

        // Up count, period 4, prescale 0
        cyc(1, 1, 1, 4, 0);
        run(7, 1, 1, 4, 0);

        // Down count, period 3, prescale 2
        cyc(1, 1, 0, 3, 2);
        run(16, 1, 0, 3, 2);

        // Clear coinciding with a tick at 7
        cyc(1, 1, 1, 10, 0);
        until_cnt(7, 1, 10, 0);
        cyc(1, 1, 1, 10, 0);
        run(4, 1, 1, 10, 0);

        // Enable low for five cycles at 2
        cyc(1, 1, 1, 10, 0);
        until_cnt(2, 1, 10, 0);
        run(5, 0, 1, 10, 0);
        run(3, 1, 1, 10, 0);

        // Period change 9 -> 5 at count 2
        cyc(1, 1, 1, 9, 0);
        until_cnt(2, 1, 9, 0);
        max_seen = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 1, 5, 0);
            if (int'(count_val) > max_seen) max_seen = int'(count_val);
        end
`ifdef PWM_CNT_SHADOW_EN
        check("period_change_max", max_seen, 9);
`else
        check("period_change_max", max_seen, 5);
`endif

        // Period 0 both directions
        run(4, 1, 1, 0, 0);
        run(6, 1, 0, 0, 1);

        // Direction changes mid-cycle
        cyc(1, 1, 1, 8, 1);
        run(7, 1, 1, 8, 1);
        run(7, 1, 0, 8, 1);
        run(5, 1, 1, 8, 1);

        // Period lowered below the running count
        cyc(1, 1, 1, 12, 0);
        until_cnt(10, 1, 12, 0);
        run(6, 1, 1, 3, 0);
        cyc(1, 1, 0, 12, 0);
        until_cnt(10, 0, 12, 0);
        run(6, 1, 0, 3, 0);

        // Randomized traffic
        r_per = 16'd6;
        r_psc = 8'd1;
        r_ud  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) r_per = CNT_W'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) r_psc = PSC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) r_ud  = ~r_ud;
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 63) == 0), r_ud,
                int'(r_per), int'(r_psc));
        end

        // Asynchronous reset mid-count at 6
        cyc(1, 1, 1, 10, 1);
        until_cnt(6, 1, 10, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_count_val", int'(count_val), 0);
        check("async_reset_ovf", int'(ovf), 0);
        #20;
        check("held_reset_count_val", int'(count_val), 0);
        model_reset();
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
        run(8, 1, 1, 10, 1);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_counter.md
PWM_COUNTER -- requirements
Module: pwm_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the counter, period and count_val width.
REQ-002 The block SHALL have parameter PSC_W, default 8, giving the prescale field width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  count enable; low freezes the counter and the prescaler.
REQ-006 count_reset  input  1  synchronous clear request, single-cycle pulse.
REQ-007 upnotdown  input  1  1 = count up, 0 = count down.
REQ-008 period  input  CNT_W  terminal count; cycle length is period+1 ticks.
REQ-009 prescale  input  PSC_W  tick divider; one tick every prescale+1 clk cycles.
REQ-010 count_val  output  CNT_W  registered counter value, consumed by the PWM generator.
REQ-011 ovf  output  1  registered one-cycle pulse, high in the cycle count_val wraps.

Function
REQ-012 The prescaler counter SHALL increment each enabled cycle and raise an internal tick when it equals the active prescale, then return to 0.
REQ-013 prescale = 0 SHALL produce a tick on every enabled cycle.
REQ-014 On a tick in up mode, count_val SHALL increment, and count_val >= active period SHALL load 0.
REQ-015 On a tick in down mode, count_val SHALL decrement, and count_val = 0 or count_val > active period SHALL load the active period.
REQ-016 ovf SHALL be high for exactly the one cycle in which a wrap load (REQ-014/015) is written, and low in all other cycles.
REQ-017 Active period = 0 SHALL hold count_val at 0 and pulse ovf on every tick.
REQ-018 A change of upnotdown SHALL take effect at the next tick with no jump in count_val.
REQ-019 count_reset SHALL clear count_val, the prescaler counter and ovf to 0 on the next edge, with priority over en and over the tick.
REQ-020 With en low, count_val and the prescaler counter SHALL hold, and ovf SHALL be 0.
REQ-021 The latency from tick to new count_val SHALL be 1 clk cycle.
REQ-022 All arithmetic SHALL be CNT_W/PSC_W bits, and no value outside 0..active period SHALL be produced after the next tick.

Reset
REQ-023 While rst_n is low, count_val, the prescaler counter, ovf and the shadow registers SHALL be 0.
REQ-024 Counting SHALL resume at the first enabled edge after rst_n deasserts.

Configuration
REQ-025 When macro PWM_CNT_SHADOW_EN is defined, period and prescale SHALL be captured into shadow registers:
- on every wrap;
- on count_reset;
- on every cycle with en low.
The shadows SHALL be the "active" values.
REQ-026 When PWM_CNT_SHADOW_EN is undefined, the period and prescale inputs SHALL be used directly as the active values, with no shadow registers.

Structure
REQ-027 Package pwm_pkg SHALL hold:
- the CNT_W and PSC_W defaults;
- the UP/DOWN direction constants;
- the functions-field bit positions shared with the PWM generator.
REQ-028 The prescaler SHALL be the sub-module pwm_prescaler (ports clk, rst_n, en, clr, prescale, tick).
REQ-029 The counter and shadow logic SHALL stay in pwm_counter.

Verification
REQ-030 Up, period=4, prescale=0, en=1: count_val 0,1,2,3,4,0, with ovf high on the 4->0 cycle only.
REQ-031 Down, period=3, prescale=2: each value held 3 cycles, sequence 3,2,1,0,3, ovf at 0->3.
REQ-032 count_reset asserted together with a tick at count_val=7: next count_val=0, prescaler restarted, ovf=0.
REQ-033 en low for 5 cycles at count_val=2: count_val stays 2, ovf 0, and counting resumes 3,4 after en returns high.
REQ-034 With the macro, period changed 9->5 at count_val=2: counting continues to 9 then wraps, and the next cycle ends at 5. Without the macro, the same stimulus wraps at 5.
REQ-035 rst_n pulsed low mid-count at count_val=6: count_val=0 and ovf=0 immediately, asynchronously, independent of clk.
